game_link_ctrl: RTL

GAME_LINK_CTRL -- requirements
Module: game_link_ctrl

---
 rtl/link_pkg.sv | 36 +++
 rtl/link_sync.sv | 18 +
 rtl/game_link_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board Pmod link: frame types, lane
// bit positions within link_in/link_out, default timing and FSM state encodings.
package link_pkg;

  typedef enum logic [1:0] {
    FT_PERSON = 2'b00,
    FT_GUESS  = 2'b01,
    FT_RESULT = 2'b10,
    FT_RESET  = 2'b11
  } frame_type_t;

  // Lane layout: [7:4] data, [3:2] type, [1] req toggle, [0] ack toggle
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 4;
  localparam int TYPE_MSB = 3;
  localparam int TYPE_LSB = 2;
  localparam int REQ_BIT  = 1;
  localparam int ACK_BIT  = 0;

  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_STABLE_CYC  = 4;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_WAIT_ACK
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_INIT,
    RX_IDLE,
    RX_QUALIFY
  } rx_state_t;

endpackage

// File: rtl/link_sync.sv
// Two-stage synchronizer for the asynchronous lanes from the peer board.
// The flops carry no reset so the synchronized value is already valid when reset releases.
module link_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/game_link_ctrl.sv
// Full-duplex toggle-handshake link between two game boards over one 8-lane Pmod.
// TX holds a frame for SETUP_CYC cycles before toggling req; RX accepts a frame once it is stable.
module game_link_ctrl
  import link_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] link_in,
  output logic [7:0] link_out,
  input  logic       send_req,
  input  logic [1:0] send_type,
  input  logic [3:0] send_data,
  output logic       send_busy,
  output logic       send_done,
  output logic       send_fail,
  output logic       rx_valid,
  output logic [1:0] rx_type,
  output logic [3:0] rx_data,
  output logic       peer_present,
  output logic       sync_reset
);

  localparam int SU_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int QU_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SU_W-1:0] SU_LAST = SU_W'(SETUP_CYC - 1);
  localparam logic [QU_W-1:0] QU_LAST = QU_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [7:0] link_s;

  link_sync #(.WIDTH(8)) u_sync (
    .clk (clk),
    .d   (link_in),
    .q   (link_s)
  );

  // TX state and registers
  tx_state_t       tx_state, tx_next;
  logic [1:0]      tx_type_q, tx_type_d;
  logic [3:0]      tx_data_q, tx_data_d;
  logic            req_q, req_d;
  logic [SU_W-1:0] setup_cnt, setup_cnt_d;
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;

  // RX state and registers
  rx_state_t       rx_state, rx_next;
  logic            init_cnt, init_cnt_d;
  logic            req_seen, req_seen_d;
  logic [6:0]      prev_s;
  logic [QU_W-1:0] qual_cnt, qual_cnt_d;
  logic [1:0]      rx_type_q, rx_type_d;
  logic [3:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            sync_reset_q, sync_reset_d;
  logic            ack_q, ack_d;
  logic            peer_q, peer_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      tx_type_q    <= '0;
      tx_data_q    <= '0;
      req_q        <= 1'b0;
      setup_cnt    <= '0;
      to_cnt       <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      rx_state     <= RX_INIT;
      init_cnt     <= 1'b0;
      req_seen     <= 1'b0;
      prev_s       <= '0;
      qual_cnt     <= '0;
      rx_type_q    <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      sync_reset_q <= 1'b0;
      ack_q        <= 1'b0;
      peer_q       <= 1'b0;
    end else begin
      tx_state     <= tx_next;
      tx_type_q    <= tx_type_d;
      tx_data_q    <= tx_data_d;
      req_q        <= req_d;
      setup_cnt    <= setup_cnt_d;
      to_cnt       <= to_cnt_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      rx_state     <= rx_next;
      init_cnt     <= init_cnt_d;
      req_seen     <= req_seen_d;
      prev_s       <= link_s[7:1];
      qual_cnt     <= qual_cnt_d;
      rx_type_q    <= rx_type_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      sync_reset_q <= sync_reset_d;
      ack_q        <= ack_d;
      peer_q       <= peer_d;
    end
  end

  // TX: latch the frame, hold it for setup, toggle req, then wait for the matching ack
  always_comb begin
    tx_next     = tx_state;
    tx_type_d   = tx_type_q;
    tx_data_d   = tx_data_q;
    req_d       = req_q;
    setup_cnt_d = setup_cnt;
    to_cnt_d    = to_cnt;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (send_req) begin
          tx_type_d   = send_type;
          tx_data_d   = send_data;
          setup_cnt_d = '0;
          tx_next     = TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (setup_cnt == SU_LAST) begin
          req_d    = ~req_q;
          to_cnt_d = '0;
          tx_next  = TX_WAIT_ACK;
        end else begin
          setup_cnt_d = setup_cnt + 1'b1;
        end
      end
      TX_WAIT_ACK: begin
        if (link_s[ACK_BIT] == req_q) begin
          done_d  = 1'b1;
          tx_next = TX_IDLE;
        end else if (to_cnt == TO_LAST) begin
          fail_d  = 1'b1;
          tx_next = TX_IDLE;
        end else if (to_cnt != '1) begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // RX: a req toggle opens qualification; any lane change restarts the stability count
  always_comb begin
    rx_next      = rx_state;
    init_cnt_d   = init_cnt;
    req_seen_d   = req_seen;
    qual_cnt_d   = qual_cnt;
    rx_type_d    = rx_type_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    sync_reset_d = 1'b0;
    ack_d        = ack_q;
    case (rx_state)
      RX_INIT: begin
        req_seen_d = link_s[REQ_BIT];
        init_cnt_d = 1'b1;
        if (init_cnt) rx_next = RX_IDLE;
      end
      RX_IDLE: begin
        if (link_s[REQ_BIT] != req_seen) begin
          qual_cnt_d = '0;
          rx_next    = RX_QUALIFY;
        end
      end
      RX_QUALIFY: begin
        if (link_s[7:1] != prev_s) begin
          qual_cnt_d = '0;
        end else if (qual_cnt == QU_LAST) begin
          rx_type_d    = link_s[TYPE_MSB:TYPE_LSB];
          rx_data_d    = link_s[DATA_MSB:DATA_LSB];
          rx_valid_d   = 1'b1;
          sync_reset_d = (link_s[TYPE_MSB:TYPE_LSB] == FT_RESET);
          ack_d        = ~ack_q;
          req_seen_d   = link_s[REQ_BIT];
          rx_next      = RX_IDLE;
        end else if (qual_cnt != '1) begin
          qual_cnt_d = qual_cnt + 1'b1;
        end
      end
      default: rx_next = RX_INIT;
    endcase
  end

  // Any sign of life from the peer wins over a simultaneous timeout
  always_comb begin
    peer_d = peer_q;
    if (fail_d) peer_d = 1'b0;
    if (done_d || rx_valid_d) peer_d = 1'b1;
  end

  assign link_out     = {tx_data_q, tx_type_q, req_q, ack_q};
  assign send_busy    = (tx_state != TX_IDLE);
  assign send_done    = done_q;
  assign send_fail    = fail_q;
  assign rx_valid     = rx_valid_q;
  assign rx_type      = rx_type_q;
  assign rx_data      = rx_data_q;
  assign peer_present = peer_q;
  assign sync_reset   = sync_reset_q;

endmodule
